// File: rtl/fetch_req_ctrl.sv
// ============================================================================
// fetch_req_ctrl : instruction-bus request controller feeding the fetch FIFO.
// Issues word fetches, tracks in-order responses, drops stale ones on branch.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_req_ctrl #(
    parameter int NUM_REQS = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    input  logic                branch_i,
    input  logic [31:0]         addr_i,
    output logic                busy_o,
    input  logic [NUM_REQS-1:0] fifo_busy_i,
    output logic                fifo_clear_o,
    output logic                fifo_valid_o,
    output logic [31:0]         fifo_addr_o,
    output logic [31:0]         fifo_rdata_o,
    output logic                fifo_err_o,
    output logic                instr_req_o,
    input  logic                instr_gnt_i,
    output logic [31:0]         instr_addr_o,
    input  logic                instr_rvalid_i,
    input  logic [31:0]         instr_rdata_i,
    input  logic                instr_err_i
);

    localparam int CNT_W = $clog2(NUM_REQS + 1);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_GNT = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [31:0]         fetch_addr_q, fetch_addr_d;
    logic [31:0]         branch_addr_q, branch_addr_d;
    logic                branch_pend_q, branch_pend_d;
    logic [31:0]         req_addr_q, req_addr_d;
    logic                wait_disc_q, wait_disc_d;
    logic [NUM_REQS-1:0] out_valid_q, out_valid_d;
    logic [NUM_REQS-1:0] out_disc_q, out_disc_d;

    logic [CNT_W-1:0]    out_cnt, fifo_cnt, cnt_s;
    logic [CNT_W:0]      occ_sum;
    logic                space, grant, grant_disc;
    logic [NUM_REQS-1:0] v_s, d_s;
    logic [31:0]         tgt_word;

    function automatic logic [CNT_W-1:0] popcnt(input logic [NUM_REQS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_REQS; i++) c = c + CNT_W'(v[i]);
        return c;
    endfunction

    assign tgt_word = {addr_i[31:2], 2'b00};
    assign out_cnt  = popcnt(out_valid_q);
    // A branch clears the FIFO this cycle, so its occupancy no longer limits issue.
    assign fifo_cnt = branch_i ? '0 : popcnt(fifo_busy_i);
    assign occ_sum  = {1'b0, out_cnt} + {1'b0, fifo_cnt};
    assign space    = occ_sum < (CNT_W+1)'(NUM_REQS);

    always_comb begin
        state_d       = state_q;
        fetch_addr_d  = fetch_addr_q;
        branch_addr_d = branch_addr_q;
        branch_pend_d = branch_pend_q;
        req_addr_d    = req_addr_q;
        wait_disc_d   = wait_disc_q;
        instr_req_o   = 1'b0;
        instr_addr_o  = req_addr_q;

        case (state_q)
            IDLE: begin
                instr_req_o  = req_i & space & (out_cnt < CNT_W'(NUM_REQS));
                instr_addr_o = branch_i      ? tgt_word :
                               branch_pend_q ? branch_addr_q : fetch_addr_q;
                if (branch_i) begin
                    fetch_addr_d  = tgt_word + ((instr_req_o & instr_gnt_i) ? 32'd4 : 32'd0);
                    branch_pend_d = ~instr_req_o;
                    branch_addr_d = tgt_word;
                end else if (instr_req_o) begin
                    branch_pend_d = 1'b0;
                    fetch_addr_d  = instr_addr_o + (instr_gnt_i ? 32'd4 : 32'd0);
                end
                if (instr_req_o && !instr_gnt_i) begin
                    state_d     = WAIT_GNT;
                    req_addr_d  = instr_addr_o;
                    wait_disc_d = 1'b0;
                end
            end
            WAIT_GNT: begin
                instr_req_o = 1'b1;
                if (branch_i) begin
                    branch_pend_d = 1'b1;
                    branch_addr_d = tgt_word;
                    fetch_addr_d  = tgt_word;
                    wait_disc_d   = 1'b1;
                end
                if (instr_gnt_i) begin
                    state_d     = IDLE;
                    wait_disc_d = 1'b0;
                    if (!wait_disc_q && !branch_i) fetch_addr_d = fetch_addr_q + 32'd4;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Tracker: retire entry 0, mark survivors stale on branch, then append grant.
    always_comb begin
        grant      = instr_req_o & instr_gnt_i;
        grant_disc = (state_q == WAIT_GNT) & (wait_disc_q | branch_i);
        v_s        = instr_rvalid_i ? (out_valid_q >> 1) : out_valid_q;
        d_s        = instr_rvalid_i ? (out_disc_q >> 1) : out_disc_q;
        if (branch_i) d_s = d_s | v_s;
        cnt_s       = popcnt(v_s);
        out_valid_d = v_s;
        out_disc_d  = d_s;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (grant && (CNT_W'(i) == cnt_s)) begin
                out_valid_d[i] = 1'b1;
                out_disc_d[i]  = grant_disc;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            fetch_addr_q  <= '0;
            branch_addr_q <= '0;
            branch_pend_q <= 1'b0;
            req_addr_q    <= '0;
            wait_disc_q   <= 1'b0;
            out_valid_q   <= '0;
            out_disc_q    <= '0;
        end else begin
            state_q       <= state_d;
            fetch_addr_q  <= fetch_addr_d;
            branch_addr_q <= branch_addr_d;
            branch_pend_q <= branch_pend_d;
            req_addr_q    <= req_addr_d;
            wait_disc_q   <= wait_disc_d;
            out_valid_q   <= out_valid_d;
            out_disc_q    <= out_disc_d;
        end
    end

    assign fifo_valid_o = instr_rvalid_i & ~out_disc_q[0] & ~branch_i;
    assign fifo_clear_o = branch_i;
    assign fifo_addr_o  = addr_i;
    assign fifo_rdata_o = instr_rdata_i;
    assign fifo_err_o   = instr_err_i;
    assign busy_o       = instr_req_o | (|out_valid_q);

`ifndef SYNTHESIS
    logic        chk_hold_q;
    logic [31:0] chk_addr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chk_hold_q <= 1'b0;
            chk_addr_q <= '0;
        end else begin
            chk_hold_q <= instr_req_o & ~instr_gnt_i;
            chk_addr_q <= instr_addr_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(instr_rvalid_i && !out_valid_q[0]))
                else $error("fetch_req_ctrl: rvalid with no outstanding request");
            assert (!chk_hold_q || (instr_req_o && instr_addr_o == chk_addr_q))
                else $error("fetch_req_ctrl: request changed before grant");
            assert (out_cnt <= CNT_W'(NUM_REQS))
                else $error("fetch_req_ctrl: outstanding count overflow");
            assert (!(fifo_valid_o && fifo_busy_i[NUM_REQS-1]))
                else $error("fetch_req_ctrl: push into full fetch FIFO");
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_req_ctrl.sv
// ============================================================================
// tb_fetch_req_ctrl : directed and random stimulus against a transaction model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_req_ctrl;

    localparam int N = 2;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         req_i, branch_i;
    logic [31:0]  addr_i;
    logic         busy_o;
    logic [N-1:0] fifo_busy_i;
    logic         fifo_clear_o, fifo_valid_o, fifo_err_o;
    logic [31:0]  fifo_addr_o, fifo_rdata_o;
    logic         instr_req_o, instr_gnt_i, instr_rvalid_i, instr_err_i;
    logic [31:0]  instr_addr_o, instr_rdata_i;

    always #5 clk_i = ~clk_i;

    fetch_req_ctrl #(.NUM_REQS(N)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .branch_i(branch_i),
        .addr_i(addr_i), .busy_o(busy_o), .fifo_busy_i(fifo_busy_i),
        .fifo_clear_o(fifo_clear_o), .fifo_valid_o(fifo_valid_o),
        .fifo_addr_o(fifo_addr_o), .fifo_rdata_o(fifo_rdata_o),
        .fifo_err_o(fifo_err_o), .instr_req_o(instr_req_o),
        .instr_gnt_i(instr_gnt_i), .instr_addr_o(instr_addr_o),
        .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
        .instr_err_i(instr_err_i)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: queue of in-flight fetches (1 = stale), the request the bus has
    // not yet accepted, and the address the instruction stream wants next.
    bit          m_q[$];
    bit          held_v, held_stale;
    logic [31:0] held_addr, m_next;

    logic        obs_req, obs_valid, obs_clear, obs_err;
    logic [31:0] obs_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        held_v     = 1'b0;
        held_stale = 1'b0;
        held_addr  = '0;
        m_next     = '0;
    endtask

    task automatic step(input bit req, input bit br, input logic [31:0] addr,
                        input logic [1:0] fb, input bit gw, input bit rw, input bit ew);
        bit          e_req, e_push, g, rv, gstale;
        int          fcnt;
        logic [31:0] e_addr, nn;
        @(negedge clk_i);
        req_i = req; branch_i = br; addr_i = addr; fifo_busy_i = fb;
        fcnt = br ? 0 : (int'(fb[0]) + int'(fb[1]));
        if (held_v) begin
            e_req  = 1'b1;
            e_addr = held_addr;
        end else begin
            e_req  = req && (m_q.size() + fcnt < N);
            e_addr = br ? {addr[31:2], 2'b00} : m_next;
        end
        g  = gw && e_req;
        rv = rw && (m_q.size() > 0) && !fb[1];
        instr_gnt_i    = g;
        instr_rvalid_i = rv;
        instr_rdata_i  = $urandom;
        instr_err_i    = ew;
        e_push = rv && !br && !m_q[0];
        #1;
        obs_req = instr_req_o; obs_addr = instr_addr_o; obs_valid = fifo_valid_o;
        obs_clear = fifo_clear_o; obs_err = fifo_err_o;
        chk("req", instr_req_o, e_req);
        if (e_req) chk("addr", instr_addr_o, e_addr);
        chk("push", fifo_valid_o, e_push);
        chk("clear", fifo_clear_o, br);
        chk("busy", busy_o, e_req || (m_q.size() > 0));
        chk("faddr", fifo_addr_o, addr);
        if (e_push) begin
            chk("rdata", fifo_rdata_o, instr_rdata_i);
            chk("err", fifo_err_o, ew);
        end
        @(posedge clk_i);
        if (rv) void'(m_q.pop_front());
        if (br) foreach (m_q[i]) m_q[i] = 1'b1;
        gstale = held_v ? (held_stale || br) : 1'b0;
        nn = br ? {addr[31:2], 2'b00} : m_next;
        if (g) begin
            m_q.push_back(gstale);
            held_v = 1'b0;
            if (!gstale) nn = nn + 32'd4;
        end else if (e_req) begin
            if (!held_v) begin
                held_v = 1'b1; held_addr = e_addr; held_stale = 1'b0;
            end else if (br) begin
                held_stale = 1'b1;
            end
        end
        m_next = nn;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && (m_q.size() > 0 || held_v); k++)
            step(1'b0, 1'b0, 32'h0, 2'b00, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        int grants;
        logic [31:0] ra;
        rst_ni = 1'b0;
        req_i = 0; branch_i = 0; addr_i = '0; fifo_busy_i = '0;
        instr_gnt_i = 0; instr_rvalid_i = 0; instr_rdata_i = '0; instr_err_i = 0;
        model_reset();
        repeat (2) @(negedge clk_i);
        #1;
        chk("rst_req", instr_req_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_valid", fifo_valid_o, 1'b0);
        rst_ni = 1'b1;

        // Back-to-back grants after a branch to 0x100
        step(1, 1, 32'h100, 2'b00, 1, 0, 0);  chk("t1_a0", obs_addr, 32'h100);
        step(1, 0, 32'h0,   2'b00, 1, 1, 0);  chk("t1_a1", obs_addr, 32'h104);
        chk("t1_push0", obs_valid, 1'b1);
        step(0, 0, 32'h0,   2'b00, 0, 1, 0);  chk("t1_push1", obs_valid, 1'b1);

        // Grant withheld for five cycles
        repeat (5) begin
            step(1, 0, 32'h0, 2'b00, 0, 0, 0);
            chk("t2_req", obs_req, 1'b1);
            chk("t2_addr", obs_addr, 32'h108);
        end
        step(0, 0, 32'h0, 2'b00, 1, 0, 0);    chk("t2_gnt", obs_addr, 32'h108);
        step(1, 0, 32'h0, 2'b00, 0, 1, 0);    chk("t2_next", obs_addr, 32'h10C);
        drain();

        // Branch with two fetches in flight
        step(1, 1, 32'h200, 2'b00, 1, 0, 0); chk("t3_a0", obs_addr, 32'h200);
        step(1, 0, 32'h0,   2'b00, 1, 0, 0); chk("t3_a1", obs_addr, 32'h204);
        step(0, 1, 32'h302, 2'b00, 0, 1, 0);
        chk("t3_clear", obs_clear, 1'b1);    chk("t3_drop0", obs_valid, 1'b0);
        step(0, 0, 32'h0,   2'b00, 0, 1, 0); chk("t3_drop1", obs_valid, 1'b0);
        step(1, 0, 32'h0,   2'b00, 1, 0, 0); chk("t3_redir", obs_addr, 32'h300);
        step(0, 0, 32'h0,   2'b00, 0, 1, 0); chk("t3_push", obs_valid, 1'b1);

        // Branch while waiting for a grant
        step(1, 1, 32'h210, 2'b00, 0, 0, 0); chk("t4_a0", obs_addr, 32'h210);
        step(1, 1, 32'h400, 2'b00, 0, 0, 0); chk("t4_hold", obs_addr, 32'h210);
        step(1, 0, 32'h0,   2'b00, 1, 0, 0); chk("t4_gnt", obs_addr, 32'h210);
        step(1, 0, 32'h0,   2'b00, 1, 1, 0);
        chk("t4_redir", obs_addr, 32'h400);  chk("t4_drop", obs_valid, 1'b0);
        step(0, 0, 32'h0,   2'b00, 0, 1, 0); chk("t4_push", obs_valid, 1'b1);
        drain();

        // FIFO occupancy throttles issue
        repeat (3) begin
            step(1, 0, 32'h0, 2'b11, 1, 0, 0);
            chk("t5_full", obs_req, 1'b0);
        end
        grants = 0;
        repeat (3) begin
            step(1, 0, 32'h0, 2'b01, 1, 0, 0);
            if (obs_req) grants++;
        end
        chk("t5_one", grants, 1);
        drain();

        // Address wrap and error response
        step(1, 1, 32'hFFFF_FFFC, 2'b00, 1, 0, 0); chk("t6_top", obs_addr, 32'hFFFF_FFFC);
        step(1, 0, 32'h0, 2'b00, 1, 1, 1);
        chk("t6_wrap", obs_addr, 32'h0);
        chk("t6_push", obs_valid, 1'b1);
        chk("t6_err", obs_err, 1'b1);
        drain();

        // Asynchronous reset while a request is held
        step(1, 0, 32'h0, 2'b00, 0, 0, 0);
        @(negedge clk_i);
        req_i = 0; branch_i = 0; instr_gnt_i = 0; instr_rvalid_i = 0; fifo_busy_i = '0;
        #1;
        chk("ar_held", instr_req_o, 1'b1);
        rst_ni = 1'b0;
        #1;
        chk("ar_req", instr_req_o, 1'b0);
        chk("ar_busy", busy_o, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            ra = $urandom;
            ra[0] = 1'b0;
            step($urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0, ra,
                 2'($urandom_range(0, 1)), $urandom_range(0, 9) < 6,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_req_ctrl.md
Name: fetch_req_ctrl

Overview:
Memory-side request controller of the instruction prefetch path. It sits directly upstream of the fetch FIFO. It issues word-aligned instruction fetches on the instruction bus and tracks up to NUM_REQS outstanding responses. It discards responses made stale by a branch, and pushes in-order valid responses into the fetch FIFO. It also drives the FIFO clear and the branch target address.

Parameters:
NUM_REQS, 2, max outstanding bus requests; equals the fetch FIFO NUM_REQS (fifo_busy_i width).

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
req_i  in  1  fetch enable from IF stage
branch_i  in  1  redirect fetch to addr_i (single-cycle pulse)
addr_i  in  32  branch target (halfword aligned)
busy_o  out  1  request pending or responses outstanding
fifo_busy_i  in  NUM_REQS  upper-entry occupancy of fetch FIFO
fifo_clear_o  out  1  FIFO clear, equals branch_i
fifo_valid_o  out  1  push response into FIFO
fifo_addr_o  out  32  equals addr_i (FIFO samples it only on clear)
fifo_rdata_o  out  32  equals instr_rdata_i
fifo_err_o  out  1  equals instr_err_i
instr_req_o  out  1  bus request
instr_gnt_i  in  1  bus grant
instr_addr_o  out  32  bus word address, [1:0]=00
instr_rvalid_i  in  1  bus response valid (in order, >=1 cycle after gnt)
instr_rdata_i  in  32  response data
instr_err_i  in  1  response bus error

Behaviour:
- Reset: state IDLE; fetch_addr_q=0; outstanding/discard vectors=0; instr_req_o=0, fifo_valid_o=0, busy_o=0.
- fetch_addr_q: word address of the next fetch. Each non-discarded grant adds 4, wrapping modulo 2^32. On an accepted redirect, it becomes {target[31:2],2'b00}+4 if granted that cycle, else {target[31:2],2'b00}.
- Outstanding tracker: NUM_REQS-entry in-order shift vector, with valid and discard bits per entry.
  - A grant appends at the lowest free entry.
  - instr_rvalid_i retires entry 0 and shifts the rest down.
  - Grant and rvalid in the same cycle are both applied.
- Space check: space = (count(outstanding) + count(fifo_busy_i)) < NUM_REQS. When branch_i=1, FIFO occupancy is treated as 0.
- FSM IDLE:
  - instr_req_o = req_i & space & (outstanding count < NUM_REQS).
  - instr_addr_o = branch_i ? {addr_i[31:2],00} : (branch_pend_q ? {branch_addr_q[31:2],00} : fetch_addr_q).
  - On req without gnt, go to WAIT_GNT and latch the issued address.
- FSM WAIT_GNT:
  - instr_req_o=1 and instr_addr_o=latched address, held stable until gnt regardless of req_i, branch_i or space.
  - On gnt, return to IDLE.
- Branch while in IDLE with a request issued that cycle: the request uses the target and is not discarded. branch_pend_q is cleared.
- Branch while in IDLE with no request issued that cycle: set branch_pend_q and branch_addr_q=addr_i. The next issued request uses branch_addr_q and clears branch_pend_q.
- Branch while in WAIT_GNT: the held request's tracker entry, when granted, is marked discard. Set branch_pend_q/branch_addr_q. A later branch overwrites branch_addr_q.
- Every branch marks all currently outstanding entries discard. This includes the entry granted in the same cycle unless it was issued with the target from IDLE.
- Push: fifo_valid_o = instr_rvalid_i & ~discard[0]. Discarded responses are dropped, even with err. No buffering: latency 0 from rvalid to push.
- fifo_clear_o=branch_i, combinational. A response arriving in a branch cycle is discarded.
- busy_o = instr_req_o | (|outstanding valid).
- Assertions:
  - rvalid with no outstanding entry.
  - instr_addr_o/instr_req_o changing while req & ~gnt.
  - Outstanding count > NUM_REQS.
  - fifo_valid_o while fifo_busy_i[NUM_REQS-1].
- Async reset mid-transaction returns to IDLE immediately. Responses arriving after reset are the bus's responsibility (asserted illegal).

Test Plan:
- Reset, then branch_i with addr_i=0x100, req_i=1, gnt every cycle, rvalid 1 cycle later -> instr_addr_o 0x100,0x104; fifo_valid_o pushes in order; never more than 2 outstanding.
- Hold gnt=0 for 5 cycles after req -> instr_req_o=1 and instr_addr_o=0x108 stable throughout; addr advances to 0x10C only after gnt.
- Two outstanding (0x200,0x204), branch to 0x302 -> fifo_clear_o pulse; both responses dropped (fifo_valid_o=0); next request addr 0x300.
- Branch to 0x400 during WAIT_GNT at 0x210 -> 0x210 still issued and its response dropped; next request 0x400, response pushed.
- fifo_busy_i=2'b11 with req_i=1 -> instr_req_o=0; busy drops to 2'b01 -> exactly one request issued.
- fetch_addr_q=0xFFFFFFFC granted -> next instr_addr_o 0x00000000; err response with instr_err_i=1 pushed with fifo_err_o=1.
